// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings, FSM states and a
// magnitude helper.
package muldiv_seq_pkg;

    localparam int unsigned IterDefault = 32;

    localparam logic [2:0] MdMult  = 3'd0;
    localparam logic [2:0] MdMultu = 3'd1;
    localparam logic [2:0] MdDiv   = 3'd2;
    localparam logic [2:0] MdDivu  = 3'd3;
    localparam logic [2:0] MdMthi  = 3'd4;
    localparam logic [2:0] MdMtlo  = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } state_e;

    // |0x8000_0000| wraps back to 0x8000_0000, which is the right unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring subtract-shift for
// divide. Purely combinational; the sequencer owns all state.
module muldiv_step (
    input  logic [31:0] acc_i,
    input  logic [31:0] mq_i,
    input  logic [31:0] operand_i,
    input  logic        is_div_i,
    output logic [31:0] acc_o,
    output logic [31:0] mq_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic        unused_trial_bit;

    always_comb begin
        sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, operand_i} : 33'd0);
        shifted = {acc_i, mq_i[31]};
        trial   = {1'b0, shifted} - {2'b00, operand_i};
        if (is_div_i) begin
            // Non-negative trial means the divisor fits; with a zero divisor this always holds.
            if (!trial[33]) begin
                acc_o = trial[31:0];
                mq_o  = {mq_i[30:0], 1'b1};
            end else begin
                acc_o = shifted[31:0];
                mq_o  = {mq_i[30:0], 1'b0};
            end
        end else begin
            acc_o = sum[32:1];
            mq_o  = {sum[0], mq_i[31:1]};
        end
    end

    assign unused_trial_bit = trial[32];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle HI/LO sequencer for MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned Iter = IterDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mq_q, mq_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_mul_op, is_div_op, signed_op, accept;
    logic        sa, sb;
    logic [31:0] a_mag, b_mag;
    logic [31:0] step_acc, step_mq;
    logic [63:0] prod_neg;

    always_comb begin
        is_mul_op = (op_i == MdMult) || (op_i == MdMultu);
        is_div_op = (op_i == MdDiv) || (op_i == MdDivu);
`ifdef MULDIV_SIGNED_EN
        signed_op = (op_i == MdMult) || (op_i == MdDiv);
`else
        signed_op = 1'b0;
`endif
        sa     = signed_op & a_i[31];
        sb     = signed_op & b_i[31];
        a_mag  = sa ? abs32(a_i) : a_i;
        b_mag  = sb ? abs32(b_i) : b_i;
        accept = start_i && !busy_o && !abort_i;
    end

    muldiv_step u_step (
        .acc_i     (acc_q),
        .mq_i      (mq_q),
        .operand_i (opnd_q),
        .is_div_i  (is_div_q),
        .acc_o     (step_acc),
        .mq_o      (step_mq)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && (is_mul_op || is_div_op)) state_d = StRun;
            StRun: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q != StIdle);
    end

    assign prod_neg = ~{acc_q, mq_q} + 64'd1;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op_i == MdMthi) begin
                        hi_d = a_i;
                    end else if (op_i == MdMtlo) begin
                        lo_d = a_i;
                    end else if (is_mul_op || is_div_op) begin
                        cnt_d    = 5'(Iter - 1);
                        acc_d    = 32'd0;
                        mq_d     = is_div_op ? a_mag : b_mag;
                        opnd_d   = is_div_op ? b_mag : a_mag;
                        is_div_d = is_div_op;
                        sa_d     = sa;
                        sb_d     = sb;
                        div0_d   = is_div_op && (b_i == 32'd0);
                    end
                end
            end
            StRun: begin
                if (!abort_i) begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                end
            end
            StFix: begin
                if (!abort_i) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : {acc_q, mq_q};
                    end else if (div0_q) begin
                        hi_d = acc_q;
                        lo_d = mq_q;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? (~mq_q + 32'd1) : mq_q;
                        hi_d = sa_q ? (~acc_q + 32'd1) : acc_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            mq_q     <= 32'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for arithmetic results and latency, plus hand
// sequences for MTHI/MTLO, abort, start-while-busy and reset mid-operation.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

`ifdef MULDIV_SIGNED_EN
    localparam bit Sgn = 1'b1;
`else
    localparam bit Sgn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NVec = 14;
    vec_t vecs [NVec];

    muldiv_seq dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .abort_i (abort),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        vecs[0]  = '{MdMultu, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE};
        vecs[1]  = '{MdMultu, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780};
        vecs[2]  = '{MdMult, 32'hFFFF_FFFD, 32'd7, Sgn ? 32'hFFFF_FFFF : 32'd6, 32'hFFFF_FFEB};
        vecs[3]  = '{MdMult, 32'h8000_0000, 32'd2, Sgn ? 32'hFFFF_FFFF : 32'd1, 32'd0};
        vecs[4]  = '{MdMultu, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0};
        vecs[5]  = '{MdDiv, 32'hFFFF_FFF9, 32'd2, Sgn ? 32'hFFFF_FFFF : 32'd1,
                     Sgn ? 32'hFFFF_FFFD : 32'h7FFF_FFFC};
        vecs[6]  = '{MdDivu, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[7]  = '{MdDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
        vecs[8]  = '{MdDiv, 32'hFFFF_FFFB, 32'd0, Sgn ? 32'd5 : 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9]  = '{MdDiv, 32'd7, 32'hFFFF_FFFE, Sgn ? 32'd1 : 32'd7, Sgn ? 32'hFFFF_FFFD : 32'd0};
        vecs[10] = '{MdDivu, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF};
        vecs[11] = '{MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, Sgn ? 32'd0 : 32'h8000_0000,
                     Sgn ? 32'h8000_0000 : 32'd0};
        vecs[12] = '{MdMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, Sgn ? 32'd0 : 32'hFFFF_FFFE, 32'd1};
        vecs[13] = '{MdDivu, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF};

        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        for (int i = 0; i < NVec; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
            chk($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'd33);
            chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            tick();
            chk($sformatf("vec%0d done single pulse", i), {31'd0, done}, 32'd0);
        end

        // MTHI then MTLO on consecutive edges.
        start = 1'b1;
        op    = MdMthi;
        a     = 32'hDEAD_BEEF;
        tick();
        chk("mthi hi", hi, 32'hDEAD_BEEF);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        op = MdMtlo;
        a  = 32'h0000_1234;
        tick();
        start = 1'b0;
        chk("mtlo lo", lo, 32'h0000_1234);
        chk("mtlo hi kept", hi, 32'hDEAD_BEEF);
        chk("mtlo done", {31'd0, done}, 32'd0);

        // Preload hi/lo, then abort a MULTU in RUN while a start-while-busy is offered.
        start = 1'b1;
        op    = MdMthi;
        a     = 32'h11;
        tick();
        op = MdMtlo;
        a  = 32'h22;
        tick();
        op = MdMultu;
        a  = 32'd3;
        b  = 32'd5;
        tick();
        op = MdMthi;
        a  = 32'h99;
        for (int k = 0; k < 9; k++) tick();
        start = 1'b0;
        chk("abort pre busy", {31'd0, busy}, 32'd1);
        chk("busy start ignored", hi, 32'h11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dcnt++;
            tick();
        end
        chk("abort no done", 32'(dcnt), 32'd0);
        chk("abort hi", hi, 32'h11);
        chk("abort lo", lo, 32'h22);

        // Abort together with start in IDLE drops the start.
        start = 1'b1;
        abort = 1'b1;
        op    = MdMultu;
        tick();
        op = MdMthi;
        a  = 32'h55;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("idle abort start busy", {31'd0, busy}, 32'd0);
        chk("idle abort mthi dropped", hi, 32'h11);

        // Abort in FIX.
        start = 1'b1;
        op    = MdMultu;
        a     = 32'd3;
        b     = 32'd5;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        chk("fix busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("fix abort busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) dcnt++;
            tick();
        end
        chk("fix abort no done", 32'(dcnt), 32'd0);
        chk("fix abort hi", hi, 32'h11);
        chk("fix abort lo", lo, 32'h22);

        // Reset mid-RUN, coinciding with abort.
        start = 1'b1;
        op    = MdMultu;
        a     = 32'hFFFF_FFFF;
        b     = 32'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst   = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        abort = 1'b0;
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        do_op(MdDivu, 32'd100, 32'd7, lat, bcnt);
        chk("post rst latency", 32'(lat), 32'd33);
        chk("post rst lo", lo, 32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
